umips_hazard: RTL and testbench

UMIPS_HAZARD -- requirements
Module: umips_hazard

---
 rtl/umips_hazard.sv | 130 +++++++++++++
 tb/tb_umips_hazard.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/umips_hazard.sv
// Hazard unit for the five-stage micro-MIPS pipeline.
// Forwards execute-stage operands and stalls or flushes the front end for
// load-use, branch-compare and HI/LO-read hazards. A 32-cycle countdown
// models the multiply/divide unit, and two saturating counters provide
// performance statistics.
//
// Handshake: this block has no valid/ready channels. Every control output
// is a level that is valid for the current cycle and is consumed by the
// pipeline registers on the next rising clk edge.
module umips_hazard (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs_d,
    input  logic [4:0]  rt_d,
    input  logic        branch_d,
    input  logic        hilo_read_d,
    input  logic [4:0]  rs_e,
    input  logic [4:0]  rt_e,
    input  logic [4:0]  write_reg_e,
    input  logic        reg_write_e,
    input  logic        mem_to_reg_e,
    input  logic        md_start_e,
    input  logic        branch_taken_e,
    input  logic [4:0]  write_reg_m,
    input  logic [4:0]  write_reg_w,
    input  logic        reg_write_m,
    input  logic        mem_to_reg_m,
    input  logic        reg_write_w,
    output logic        stall_f,
    output logic        stall_d,
    output logic        flush_d,
    output logic        flush_e,
    output logic [1:0]  forward_a_e,
    output logic [1:0]  forward_b_e,
    output logic        md_busy,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_events,
    output logic [0:0]  md_state
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] MD_BUSY = 1'b1;
    localparam logic [5:0] MD_LATENCY = 6'd32;

    logic [5:0] md_count;
    logic [0:0] state_q;
    logic [0:0] state_n;

    // A producer is only meaningful when it writes a register other than $0.
    logic valid_e, valid_m_fwd, valid_m_load, valid_w;
    assign valid_e      = reg_write_e  && (write_reg_e != 5'd0);
    assign valid_m_fwd  = reg_write_m  && (write_reg_m != 5'd0);
    assign valid_m_load = mem_to_reg_m && (write_reg_m != 5'd0);
    assign valid_w      = reg_write_w  && (write_reg_w != 5'd0);

    logic lw_stall, br_stall, md_stall;
    assign lw_stall = mem_to_reg_e && valid_e &&
                      ((write_reg_e == rs_d) || (write_reg_e == rt_d));
    assign br_stall = branch_d &&
                      ((valid_e      && ((write_reg_e == rs_d) || (write_reg_e == rt_d))) ||
                       (valid_m_load && ((write_reg_m == rs_d) || (write_reg_m == rt_d))));
    assign md_busy  = (md_count != 6'd0);
    // md_count is cleared asynchronously, so md_stall is 0 throughout reset.
    assign md_stall = hilo_read_d && md_busy;
    assign md_state = state_q;

    // Operand bypass select; the younger memory-stage result wins over writeback.
    always_comb begin
        forward_a_e = 2'b00;
        forward_b_e = 2'b00;
        if (valid_m_fwd && (write_reg_m == rs_e))   forward_a_e = 2'b10;
        else if (valid_w && (write_reg_w == rs_e))  forward_a_e = 2'b01;
        if (valid_m_fwd && (write_reg_m == rt_e))   forward_b_e = 2'b10;
        else if (valid_w && (write_reg_w == rt_e))  forward_b_e = 2'b01;
    end

    // Pipeline control: a taken branch squashes everything, stalls otherwise insert a bubble.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (branch_taken_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (lw_stall || br_stall || md_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    // Next state for the multiply/divide FSM, kept in step with md_count.
    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:    if (md_start_e) state_n = MD_BUSY;
            MD_BUSY: if (!md_start_e && (md_count == 6'd1)) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Multiply/divide countdown; a new start always reloads the full latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            md_count <= 6'd0;
            state_q  <= IDLE;
        end else begin
            state_q <= state_n;
            if (md_start_e)
                md_count <= MD_LATENCY;
            else if (md_count != 6'd0)
                md_count <= md_count - 6'd1;
        end
    end

    // Saturating statistics: decode-stall cycles and taken-branch flushes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= 16'd0;
            flush_events <= 16'd0;
        end else begin
            if (stall_d && (stall_cycles != 16'hFFFF))
                stall_cycles <= stall_cycles + 16'd1;
            if (branch_taken_e && (flush_events != 16'hFFFF))
                flush_events <= flush_events + 16'd1;
        end
    end

endmodule

// File: tb/tb_umips_hazard.sv
// Directed testbench for umips_hazard with hand-computed expectations.
module tb_umips_hazard;

    logic        clk;
    logic        rst;
    logic [4:0]  rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
    logic        branch_d, hilo_read_d, reg_write_e, mem_to_reg_e, md_start_e;
    logic        branch_taken_e, reg_write_m, mem_to_reg_m, reg_write_w;
    logic        stall_f, stall_d, flush_d, flush_e, md_busy;
    logic [1:0]  forward_a_e, forward_b_e;
    logic [15:0] stall_cycles, flush_events;
    logic [0:0]  md_state;

    int n_asserts = 0;
    int n_fail    = 0;

    umips_hazard dut (
        .clk(clk), .rst(rst),
        .rs_d(rs_d), .rt_d(rt_d), .branch_d(branch_d), .hilo_read_d(hilo_read_d),
        .rs_e(rs_e), .rt_e(rt_e), .write_reg_e(write_reg_e),
        .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e),
        .md_start_e(md_start_e), .branch_taken_e(branch_taken_e),
        .write_reg_m(write_reg_m), .write_reg_w(write_reg_w),
        .reg_write_m(reg_write_m), .mem_to_reg_m(mem_to_reg_m),
        .reg_write_w(reg_write_w),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .md_busy(md_busy), .stall_cycles(stall_cycles),
        .flush_events(flush_events), .md_state(md_state)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one clock; inputs change 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        rs_d = 0; rt_d = 0; branch_d = 0; hilo_read_d = 0;
        rs_e = 0; rt_e = 0; write_reg_e = 0; reg_write_e = 0; mem_to_reg_e = 0;
        md_start_e = 0; branch_taken_e = 0;
        write_reg_m = 0; write_reg_w = 0; reg_write_m = 0; mem_to_reg_m = 0;
        reg_write_w = 0;
    endtask

    task automatic check_ctrl(input string tag, input logic [3:0] exp_fdfe_sfsd);
        check(tag, {flush_d, flush_e, stall_f, stall_d}, {28'd0, exp_fdfe_sfsd});
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        settle();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0;
        #3;
        // reset state
        check("rst_md_busy", md_busy, 0);
        check("rst_stall_cycles", stall_cycles, 0);
        check("rst_flush_events", flush_events, 0);
        check("rst_md_state", md_state, 0);
        check_ctrl("rst_ctrl", 4'b0000);
        check("rst_fwd", {forward_a_e, forward_b_e}, 0);
        tick();
        rst = 1'b1;
        tick();

        // forwarding priority
        rs_e = 5; rt_e = 5; write_reg_m = 5; reg_write_m = 1; write_reg_w = 5; reg_write_w = 1;
        settle();
        check("fwd_a_mem_wins", forward_a_e, 2'b10);
        check("fwd_b_mem_wins", forward_b_e, 2'b10);
        write_reg_m = 0;
        settle();
        check("fwd_a_wb", forward_a_e, 2'b01);
        reg_write_w = 0;
        settle();
        check("fwd_a_none", forward_a_e, 2'b00);
        write_reg_m = 5; reg_write_m = 0; reg_write_w = 1; rt_e = 6;
        settle();
        check("fwd_a_wb_m_disabled", forward_a_e, 2'b01);
        check("fwd_b_nomatch", forward_b_e, 2'b00);
        rs_e = 0; write_reg_w = 0; reg_write_m = 1; write_reg_m = 0;
        settle();
        check("fwd_a_reg_zero", forward_a_e, 2'b00);
        clear_inputs();
        settle();
        check("idle_stall_cycles", stall_cycles, 0);

        // load-use stall for one cycle, then forward from memory
        mem_to_reg_e = 1; reg_write_e = 1; write_reg_e = 8; rt_d = 8;
        settle();
        check_ctrl("lw_ctrl", 4'b0111);
        tick();
        check("lw_stall_cycles", stall_cycles, 1);
        clear_inputs();
        rt_e = 8; write_reg_m = 8; reg_write_m = 1; mem_to_reg_m = 1;
        settle();
        check("lw_fwd_b", forward_b_e, 2'b10);
        check_ctrl("lw_released", 4'b0000);
        tick();
        check("lw_stall_cycles_hold", stall_cycles, 1);

        // taken branch beats a load-use stall
        clear_inputs();
        mem_to_reg_e = 1; reg_write_e = 1; write_reg_e = 8; rt_d = 8; branch_taken_e = 1;
        settle();
        check_ctrl("br_prio_ctrl", 4'b1100);
        tick();
        check("br_prio_flush_events", flush_events, 1);
        check("br_prio_stall_cycles", stall_cycles, 1);

        // branch compare hazards (no clock edges)
        clear_inputs();
        branch_d = 1; rs_d = 9; reg_write_e = 1; write_reg_e = 9;
        settle();
        check_ctrl("br_stall_e", 4'b0111);
        reg_write_e = 0; write_reg_m = 9; mem_to_reg_m = 1;
        settle();
        check_ctrl("br_stall_m", 4'b0111);
        mem_to_reg_m = 0; reg_write_m = 1;
        settle();
        check_ctrl("br_no_stall_alu_m", 4'b0000);
        rs_d = 0; write_reg_e = 0; reg_write_e = 1;
        settle();
        check_ctrl("br_no_stall_r0", 4'b0000);

        // mult/div busy window, starting from clean counters
        clear_inputs();
        do_reset();
        md_start_e = 1;
        tick();
        md_start_e = 0; hilo_read_d = 1;
        settle();
        check("md_busy_start", md_busy, 1);
        check("md_state_busy", md_state, 1);
        for (int i = 0; i < 32; i++) begin
            check("md_stall_d", stall_d, 1);
            tick();
        end
        check("md_busy_done", md_busy, 0);
        check("md_state_idle", md_state, 0);
        check("md_release", stall_d, 0);
        check("md_stall_cycles", stall_cycles, 32);

        // restart at md_count=10 reloads 32
        hilo_read_d = 0;
        md_start_e = 1;
        tick();
        md_start_e = 0;
        repeat (22) tick();
        check("restart_busy10", md_busy, 1);
        md_start_e = 1;
        tick();
        md_start_e = 0;
        repeat (31) tick();
        check("restart_busy_at1", md_busy, 1);
        tick();
        check("restart_done", md_busy, 0);

        // asynchronous reset at md_count=20
        md_start_e = 1;
        tick();
        md_start_e = 0; hilo_read_d = 1;
        repeat (12) tick();
        check("pre_rst_busy", md_busy, 1);
        branch_taken_e = 1;
        tick();
        branch_taken_e = 0;
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_busy", md_busy, 0);
        check("async_rst_stall_cycles", stall_cycles, 0);
        check("async_rst_flush_events", flush_events, 0);
        check("async_rst_stall_d", stall_d, 0);
        rs_e = 3; write_reg_w = 3; reg_write_w = 1;
        #1;
        check("rst_comb_fwd", forward_a_e, 2'b01);
        #2;
        rst = 1'b1;
        tick();
        check("post_rst_mfhi", stall_d, 0);
        check("post_rst_count", stall_cycles, 0);

        // saturation of the stall counter
        clear_inputs();
        mem_to_reg_e = 1; reg_write_e = 1; write_reg_e = 4; rs_d = 4;
        repeat (65534) tick();
        check("sat_65534", stall_cycles, 16'hFFFE);
        tick();
        check("sat_65535", stall_cycles, 16'hFFFF);
        repeat (5) tick();
        check("sat_hold", stall_cycles, 16'hFFFF);
        clear_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
